trace_stream_buffer: RTL and testbench

Capture FIFO that sits directly downstream of the processor datapath's trace outputs. It records one {addr, inst, data} trace entry per asserted trace-valid cycle and drains entries as a 32-bit val/rdy word stream toward the Caravel host/debug logic, three words per entry. A saturating drop counter records entries lost to a full buffer, so the core never stalls on trace.

---
 rtl/trace_stream_buffer.sv | 116 +++++++++++
 tb/tb_trace_stream_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_buffer.sv
// Trace capture FIFO. It stores one {addr, inst, data} entry per committed instruction
// and drains each entry as three 32-bit val/rdy words. Entries that arrive while the
// buffer is full are dropped and counted, so the core never stalls on trace.
//
//   state  | meaning
//   W_ADDR | presenting the head entry's PC word
//   W_INST | presenting the head entry's instruction word
//   W_DATA | presenting the head entry's writeback word; a handshake here pops
module trace_stream_buffer #(
  parameter int DEPTH = 8,
  parameter int DROPW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   trace_val,
  input  logic [31:0]            trace_addr,
  input  logic [31:0]            trace_inst,
  input  logic [31:0]            trace_data,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROPW-1:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    W_ADDR = 2'd0,
    W_INST = 2'd1,
    W_DATA = 2'd2
  } word_state_t;

  logic [95:0]      mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_q;
  logic [DROPW-1:0] drop_q;
  word_state_t      state;
  word_state_t      state_nxt;

  logic        full;
  logic        push;
  logic        drop;
  logic        hs;
  logic        pop;
  logic [95:0] head;

  // Full is taken from the registered count, so a pop in the same cycle does not
  // make room for a push.
  always_comb begin
    full = (cnt_q == CW'(DEPTH));
    push = en && trace_val && !full && !clear;
    drop = en && trace_val && full && !clear;
    hs   = out_val && out_rdy;
    pop  = hs && (state == W_DATA) && !clear;
    head = mem[rptr];
  end

  always_comb begin
    state_nxt = state;
    if (hs) begin
      case (state)
        W_ADDR:  state_nxt = W_INST;
        W_INST:  state_nxt = W_DATA;
        W_DATA:  state_nxt = W_ADDR;
        default: state_nxt = W_ADDR;
      endcase
    end
  end

  always_comb begin
    out_val  = (cnt_q != '0);
    out_last = out_val && (state == W_DATA);
    out_data = head[95:64];
    case (state)
      W_ADDR:  out_data = head[95:64];
      W_INST:  out_data = head[63:32];
      W_DATA:  out_data = head[31:0];
      default: out_data = head[95:64];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= W_ADDR;
      wptr   <= '0;
      rptr   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {trace_addr, trace_inst, trace_data};
  end

  assign count      = cnt_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_stream_buffer.sv
// Bench for trace_stream_buffer: directed scenarios plus random traffic, with every
// cycle compared against a queue-based model of the entry stream.
module tb_trace_stream_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, en, clear, trace_val, out_rdy;
  logic [31:0] trace_addr, trace_inst, trace_data;

  logic        out_val, out_last, out_val4, out_last4;
  logic [31:0] out_data, out_data4;
  logic [3:0]  count, count4;
  logic [15:0] drop_count;
  logic [3:0]  drop_count4;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [95:0] q[$];
  int          widx;
  int          drops;

  always #5 clk = ~clk;

  trace_stream_buffer #(.DEPTH(DEPTH), .DROPW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .trace_val(trace_val),
    .trace_addr(trace_addr), .trace_inst(trace_inst), .trace_data(trace_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .count(count), .drop_count(drop_count)
  );

  trace_stream_buffer #(.DEPTH(DEPTH), .DROPW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .trace_val(trace_val),
    .trace_addr(trace_addr), .trace_inst(trace_inst), .trace_data(trace_data),
    .out_val(out_val4), .out_rdy(out_rdy), .out_data(out_data4), .out_last(out_last4),
    .count(count4), .drop_count(drop_count4)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word();
    logic [95:0] e;
    e = q[0];
    return (widx == 0) ? e[95:64] : (widx == 1) ? e[63:32] : e[31:0];
  endfunction

  // Called at the falling edge with inputs for this cycle already applied: compare,
  // advance the model across the next rising edge, and return at the next falling edge.
  task automatic tick();
    bit exp_val, full, hs;
    exp_val = (q.size() != 0);
    chk("out_val", out_val, exp_val);
    chk("out_last", out_last, exp_val && widx == 2);
    chk("count", count, q.size());
    chk("drop16", drop_count, (drops > 16'hFFFF) ? 16'hFFFF : drops);
    chk("drop4", drop_count4, (drops > 15) ? 15 : drops);
    chk("count4", count4, q.size());
    chk("out_val4", out_val4, exp_val);
    if (exp_val) begin
      chk("out_data", out_data, exp_word());
      chk("out_data4", out_data4, exp_word());
    end

    if (rst || clear) begin
      q.delete();
      widx  = 0;
      drops = 0;
    end else begin
      full = (q.size() == DEPTH);
      hs   = exp_val && out_rdy;
      if (hs) begin
        if (widx == 2) begin
          void'(q.pop_front());
          widx = 0;
        end else widx++;
      end
      if (en && trace_val) begin
        if (full) drops++;
        else q.push_back({trace_addr, trace_inst, trace_data});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; en = 1; trace_val = 0;
  endtask

  task automatic set_entry(input logic [31:0] a, input logic [31:0] i, input logic [31:0] d);
    trace_val = 1; trace_addr = a; trace_inst = i; trace_data = d;
  endtask

  initial begin
    rst = 1; clear = 0; en = 0; trace_val = 0; out_rdy = 0;
    trace_addr = 0; trace_inst = 0; trace_data = 0;
    q.delete(); widx = 0; drops = 0;
    @(posedge clk);
    @(negedge clk);
    tick();  // reset held: reset-state outputs

    // single entry, consumer always ready
    idle_inputs(); out_rdy = 1;
    set_entry(32'h0000_0200, 32'h00A0_0093, 32'h0000_000A);
    tick();
    trace_val = 0;
    repeat (5) tick();

    // stalled consumer holds the addr word
    out_rdy = 0;
    set_entry(32'h0000_0200, 32'h00A0_0093, 32'h0000_000A);
    tick();
    trace_val = 0;
    repeat (5) tick();
    out_rdy = 1;
    repeat (4) tick();

    // overflow: DEPTH+3 pushes against a stalled consumer, then full drain
    out_rdy = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_entry(4 * i, $urandom, $urandom);
      tick();
    end
    trace_val = 0;
    chk("drops_after_overflow", drop_count, 16'd3);
    out_rdy = 1;
    repeat (3 * DEPTH + 2) tick();

    // fill to DEPTH-1, then push exactly on each popping handshake across wrap
    clear = 1; tick(); clear = 0;
    out_rdy = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      set_entry($urandom, $urandom, $urandom);
      tick();
    end
    out_rdy = 1;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      trace_val = (widx == 2);
      trace_addr = $urandom; trace_inst = $urandom; trace_data = $urandom;
      tick();
      chk("count_steady", count, DEPTH - 1);
    end
    trace_val = 0;
    repeat (3 * DEPTH + 2) tick();

    // clear mid-entry together with a push
    set_entry(32'h1234, 32'h5678, 32'h9ABC);
    out_rdy = 1;
    tick();
    trace_val = 0;
    repeat (2) tick();
    clear = 1;
    set_entry(32'hDEAD, 32'hBEEF, 32'hCAFE);
    tick();
    clear = 0; trace_val = 0;
    chk("count_after_clear", count, 0);
    repeat (2) tick();

    // saturation on the narrow counter, then en low ignores trace_val
    out_rdy = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      set_entry($urandom, $urandom, $urandom);
      tick();
    end
    chk("drop4_saturated", drop_count4, 4'hF);
    en = 0;
    repeat (4) tick();
    chk("drop16_en_low", drop_count, 16'd20);
    en = 1; trace_val = 0;
    out_rdy = 1;
    repeat (3 * DEPTH + 2) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      clear     = ($urandom_range(0, 127) == 0);
      en        = ($urandom_range(0, 9) != 0);
      trace_val = ($urandom_range(0, 99) < 45);
      out_rdy   = ($urandom_range(0, 99) < 70);
      trace_addr = $urandom; trace_inst = $urandom; trace_data = $urandom;
      tick();
    end

    // reset mid-drain
    idle_inputs(); out_rdy = 1;
    set_entry(32'hA0, 32'hA1, 32'hA2);
    tick();
    trace_val = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("out_val_after_rst", out_val, 1'b0);
    set_entry(32'hB0, 32'hB1, 32'hB2);
    tick();
    trace_val = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
